xeng_vacc: RTL and testbench



---
 rtl/xeng_pkg.sv | 52 +++++
 rtl/vacc_bram.sv | 31 +++
 rtl/xeng_vacc.sv | 186 ++++++++++++++++++
 tb/tb_xeng_vacc.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/xeng_pkg.sv
// Shared X-engine definitions: tap-chain word widths, log2 and saturation helpers
// used by the tap, cmac and vector-accumulator blocks.
package xeng_pkg;

  typedef enum logic [0:0] {
    WAIT_SYNC = 1'b0,
    RUN       = 1'b1
  } vacc_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int in_field_w(input int serial_bits, input int pfac_bits, input int bitw);
    return 2 * bitw + 1 + pfac_bits + serial_bits;
  endfunction

  function automatic int n_fields(input int npols);
    return 2 * npols * npols;
  endfunction

  function automatic int acc_width(input int serial_bits, input int pfac_bits, input int bitw,
                                   input int npols);
    return n_fields(npols) * in_field_w(serial_bits, pfac_bits, bitw);
  endfunction

  // Largest positive value of a w-bit signed field, held in 64 bits.
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic sat_hit(input logic signed [63:0] v, input int w);
    return (v > sat_max(w)) || (v < (-sat_max(w) - 64'sd1));
  endfunction

  function automatic logic signed [63:0] sat_val(input logic signed [63:0] v, input int w);
    if (v > sat_max(w)) return sat_max(w);
    if (v < (-sat_max(w) - 64'sd1)) return -sat_max(w) - 64'sd1;
    return v;
  endfunction

  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b, input int w);
    return sat_val(a + b, w);
  endfunction

endpackage

// File: rtl/vacc_bram.sv
// Simple dual-port accumulation RAM; the read path is a LATENCY-deep register chain.
module vacc_bram #(
  parameter int DEPTH   = 1024,
  parameter int WIDTH   = 256,
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_pipe [LATENCY];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_pipe[0] <= mem[rd_addr];
    for (int i = 1; i < LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign rd_data = rd_pipe[LATENCY-1];

endmodule

// File: rtl/xeng_vacc.sv
// Long-term vector accumulator behind the X-engine tap chain: read-modify-write
// integration in one RAM, with the final vector of each dump streamed out instead of stored.
module xeng_vacc
  import xeng_pkg::*;
#(
  parameter int SERIAL_ACC_LEN_BITS = 7,
  parameter int P_FACTOR_BITS       = 0,
  parameter int BITWIDTH            = 4,
  parameter int N_POLS              = 2,
  parameter int VEC_LEN             = 1024,
  parameter int OUT_FIELD_W         = 32,
  parameter int BRAM_LATENCY        = 2,
  localparam int N_FIELDS   = n_fields(N_POLS),
  localparam int IN_FIELD_W = in_field_w(SERIAL_ACC_LEN_BITS, P_FACTOR_BITS, BITWIDTH),
  localparam int ACC_WIDTH  = N_FIELDS * IN_FIELD_W,
  localparam int ADDR_W     = clog2(VEC_LEN),
  localparam int OUT_W      = N_FIELDS * OUT_FIELD_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sync_in,
  input  logic [15:0]          acc_len,
  input  logic [ACC_WIDTH-1:0] acc_in,
  input  logic                 valid_in,
  output logic [OUT_W-1:0]     dout,
  output logic                 dout_valid,
  output logic [ADDR_W-1:0]    dout_addr,
  output logic                 dout_last,
  output logic                 sync_out,
  output logic                 ovfl
);

  localparam int L     = BRAM_LATENCY + 2;
  localparam int SUM_W = ((OUT_FIELD_W > IN_FIELD_W) ? OUT_FIELD_W : IN_FIELD_W) + 1;

  typedef struct packed {
    logic [ACC_WIDTH-1:0] data;
    logic [ADDR_W-1:0]    addr;
    logic                 first;
    logic                 last;
  } word_t;

  vacc_state_e state_q, state_d;
  logic [15:0] len_q, len_d, vec_ctr_q, vec_ctr_d, cur_len, cur_vec;
  logic [ADDR_W-1:0] addr_ctr_q, addr_ctr_d, cur_addr;
  logic accept, in_first, in_last, addr_wrap;

  // sync_in takes effect on the word presented with it, so counters are muxed before use.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    vec_ctr_d  = vec_ctr_q;
    addr_ctr_d = addr_ctr_q;
    cur_len    = len_q;
    cur_vec    = vec_ctr_q;
    cur_addr   = addr_ctr_q;
    if (sync_in) begin
      state_d    = RUN;
      len_d      = (acc_len == 16'd0) ? 16'd1 : acc_len;
      cur_len    = len_d;
      cur_vec    = '0;
      cur_addr   = '0;
      vec_ctr_d  = '0;
      addr_ctr_d = '0;
    end
    accept    = valid_in && (sync_in || (state_q == RUN));
    in_first  = (cur_vec == 16'd0);
    in_last   = (cur_vec == (cur_len - 16'd1));
    addr_wrap = (cur_addr == ADDR_W'(VEC_LEN - 1));
    if (accept) begin
      addr_ctr_d = addr_wrap ? '0 : cur_addr + ADDR_W'(1);
      if (addr_wrap) vec_ctr_d = in_last ? 16'd0 : cur_vec + 16'd1;
    end
  end

  word_t in_word, rd_word;
  word_t word_pipe_q [BRAM_LATENCY];
  word_t word_pipe_d [BRAM_LATENCY];
  logic [L-1:0] vld_pipe_q, vld_pipe_d, sync_pipe_q, sync_pipe_d;

  always_comb begin
    in_word.data  = acc_in;
    in_word.addr  = cur_addr;
    in_word.first = in_first;
    in_word.last  = in_last;
    word_pipe_d[0] = in_word;
    for (int i = 1; i < BRAM_LATENCY; i++) word_pipe_d[i] = word_pipe_q[i-1];
    vld_pipe_d  = {vld_pipe_q[L-2:0], accept};
    sync_pipe_d = {sync_pipe_q[L-2:0], sync_in};
  end

  // The word leaves the delay line in the same cycle its RAM read data arrives.
  assign rd_word = word_pipe_q[BRAM_LATENCY-1];

  logic [OUT_W-1:0] rd_data;
  logic [N_FIELDS-1:0][SUM_W-1:0] sum_d, add_sum_q;
  logic [ADDR_W-1:0] add_addr_q, out_addr_q;
  logic add_last_q, out_last_q, out_end_q;
  logic [OUT_W-1:0] out_data_d, out_data_q;
  logic [N_FIELDS-1:0] clip;
  logic ovfl_q, ovfl_d, out_end_d;

  for (genvar k = 0; k < N_FIELDS; k++) begin : g_field
    logic signed [OUT_FIELD_W-1:0] ram_f;
    logic signed [IN_FIELD_W-1:0]  in_f;
    logic signed [63:0]            sum_ext;

    assign ram_f    = rd_data[k*OUT_FIELD_W +: OUT_FIELD_W];
    assign in_f     = rd_word.data[k*IN_FIELD_W +: IN_FIELD_W];
    assign sum_d[k] = (rd_word.first ? SUM_W'(0) : SUM_W'(ram_f)) + SUM_W'(in_f);

    assign sum_ext  = 64'($signed(add_sum_q[k]));
    assign clip[k]  = sat_hit(sum_ext, OUT_FIELD_W);
    assign out_data_d[k*OUT_FIELD_W +: OUT_FIELD_W] = OUT_FIELD_W'(sat_val(sum_ext, OUT_FIELD_W));
  end

  always_comb begin
    out_end_d = (add_addr_q == ADDR_W'(VEC_LEN - 1));
    ovfl_d    = sync_in ? 1'b0 : (ovfl_q | (vld_pipe_q[BRAM_LATENCY] & (|clip)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= WAIT_SYNC;
      len_q       <= '0;
      vec_ctr_q   <= '0;
      addr_ctr_q  <= '0;
      vld_pipe_q  <= '0;
      sync_pipe_q <= '0;
      for (int i = 0; i < BRAM_LATENCY; i++) word_pipe_q[i] <= '0;
      add_sum_q   <= '0;
      add_addr_q  <= '0;
      add_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      out_end_q   <= 1'b0;
      ovfl_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      vec_ctr_q   <= vec_ctr_d;
      addr_ctr_q  <= addr_ctr_d;
      vld_pipe_q  <= vld_pipe_d;
      sync_pipe_q <= sync_pipe_d;
      word_pipe_q <= word_pipe_d;
      ovfl_q      <= ovfl_d;
      if (vld_pipe_q[BRAM_LATENCY-1]) begin
        add_sum_q  <= sum_d;
        add_addr_q <= rd_word.addr;
        add_last_q <= rd_word.last;
      end
      if (vld_pipe_q[BRAM_LATENCY]) begin
        out_data_q <= out_data_d;
        out_addr_q <= add_addr_q;
        out_last_q <= add_last_q;
        out_end_q  <= out_end_d;
      end
    end
  end

  // Last-vector words are emitted rather than written back; the next integration's
  // first vector ignores whatever the RAM holds for that address.
  vacc_bram #(
    .DEPTH  (VEC_LEN),
    .WIDTH  (OUT_W),
    .LATENCY(BRAM_LATENCY),
    .ADDR_W (ADDR_W)
  ) u_bram (
    .clk    (clk),
    .wr_en  (vld_pipe_q[L-1] & ~out_last_q),
    .wr_addr(out_addr_q),
    .wr_data(out_data_q),
    .rd_en  (accept),
    .rd_addr(cur_addr),
    .rd_data(rd_data)
  );

  assign dout       = out_data_q;
  assign dout_addr  = out_addr_q;
  assign dout_valid = vld_pipe_q[L-1] & out_last_q;
  assign dout_last  = vld_pipe_q[L-1] & out_last_q & out_end_q;
  assign sync_out   = sync_pipe_q[L-1];
  assign ovfl       = ovfl_q;

endmodule

// File: tb/tb_xeng_vacc.sv
// Scoreboard bench for xeng_vacc: two instances (32-bit and 17-bit output fields) share
// one stimulus stream; a reference integrator predicts every dump word and its cycle.
module tb_xeng_vacc;
  localparam int VEC_LEN = 8;
  localparam int BL      = 2;
  localparam int L       = BL + 2;
  localparam int NF      = 8;

  logic clk = 1'b0;
  logic rst, sync_in, valid_in;
  logic [15:0]  acc_len;
  logic [127:0] acc_in;
  logic [255:0] dout_a;
  logic [135:0] dout_b;
  logic [2:0]   da_a, da_b;
  logic dv_a, dl_a, so_a, ov_a, dv_b, dl_b, so_b, ov_b;

  xeng_vacc #(.VEC_LEN(VEC_LEN), .OUT_FIELD_W(32), .BRAM_LATENCY(BL)) dut_a (
    .clk(clk), .rst(rst), .sync_in(sync_in), .acc_len(acc_len), .acc_in(acc_in),
    .valid_in(valid_in), .dout(dout_a), .dout_valid(dv_a), .dout_addr(da_a),
    .dout_last(dl_a), .sync_out(so_a), .ovfl(ov_a));

  xeng_vacc #(.VEC_LEN(VEC_LEN), .OUT_FIELD_W(17), .BRAM_LATENCY(BL)) dut_b (
    .clk(clk), .rst(rst), .sync_in(sync_in), .acc_len(acc_len), .acc_in(acc_in),
    .valid_in(valid_in), .dout(dout_b), .dout_valid(dv_b), .dout_addr(da_b),
    .dout_last(dl_b), .sync_out(so_b), .ovfl(ov_b));

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] d32;
    logic [135:0] d17;
    logic [2:0]   addr;
    logic         last;
    int           cyc;
  } exp_t;

  exp_t sbq[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit exp_sync [0:4095];

  bit run = 0;
  bit m_ov32 = 0, m_ov17 = 0;
  int m_len = 1, m_vec = 0, m_addr = 0;
  longint m32 [VEC_LEN][NF];
  longint m17 [VEC_LEN][NF];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint hi;
    hi = (longint'(1) <<< (w - 1)) - 1;
    if (v > hi) return hi;
    if (v < -hi - 1) return -hi - 1;
    return v;
  endfunction

  function automatic logic [127:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock of stimulus; the reference integrator sees exactly what the DUTs see.
  task automatic step(input logic v, input logic s, input logic [15:0] len, input logic [127:0] w);
    logic signed [15:0] f;
    longint x, s32, s17;
    bit first, last;
    exp_t e;
    @(posedge clk);
    #1;
    valid_in = v; sync_in = s; acc_len = len; acc_in = w;
    if (cyc + L < 4096) exp_sync[cyc + L] = s;
    if (s) begin
      run = 1; m_len = (len == 16'd0) ? 1 : int'(len);
      m_vec = 0; m_addr = 0; m_ov32 = 0; m_ov17 = 0;
    end
    if (v && run) begin
      first = (m_vec == 0);
      last  = (m_vec == m_len - 1);
      e.d32 = '0; e.d17 = '0;
      for (int k = 0; k < NF; k++) begin
        f = w[k*16 +: 16];
        x = f;
        s32 = (first ? 0 : m32[m_addr][k]) + x;
        s17 = (first ? 0 : m17[m_addr][k]) + x;
        if (sat(s32, 32) != s32) m_ov32 = 1;
        if (sat(s17, 17) != s17) m_ov17 = 1;
        s32 = sat(s32, 32); s17 = sat(s17, 17);
        m32[m_addr][k] = s32; m17[m_addr][k] = s17;
        e.d32[k*32 +: 32] = s32[31:0];
        e.d17[k*17 +: 17] = s17[16:0];
      end
      if (last) begin
        e.addr = m_addr[2:0];
        e.last = (m_addr == VEC_LEN - 1);
        e.cyc  = cyc + L;
        sbq.push_back(e);
      end
      if (m_addr == VEC_LEN - 1) begin
        m_addr = 0;
        m_vec  = last ? 0 : m_vec + 1;
      end else begin
        m_addr++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'd0, 128'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      chk("dout_late", 256'(cyc), 256'(sbq[0].cyc));
      void'(sbq.pop_front());
    end
    if (dv_a || dv_b) begin
      chk("dv_b_vs_a", dv_b, dv_a);
      if (sbq.size() == 0) begin
        chk("dout_spurious", 256'(sbq.size()), 256'd1);
      end else begin
        e = sbq.pop_front();
        chk("dout_cycle", 256'(cyc), 256'(e.cyc));
        chk("dout_a", dout_a, e.d32);
        chk("dout_b", dout_b, e.d17);
        chk("addr_a", da_a, e.addr);
        chk("addr_b", da_b, e.addr);
        chk("last_a", dl_a, e.last);
        chk("last_b", dl_b, e.last);
      end
    end
    if (cyc < 4096) begin
      chk("sync_out_a", so_a, exp_sync[cyc]);
      chk("sync_out_b", so_b, exp_sync[cyc]);
    end
  end

  initial begin
    logic [127:0] pat, w;
    if (VEC_LEN <= L) begin
      $display("FAIL params: VEC_LEN %0d must exceed L %0d", VEC_LEN, L);
      $fatal(1);
    end
    rst = 1'b1; sync_in = 1'b0; valid_in = 1'b0; acc_len = '0; acc_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout_a", dout_a, 256'd0);
    chk("rst_dout_b", dout_b, 256'd0);
    chk("rst_dv", {dv_a, dv_b}, 256'd0);
    chk("rst_addr", {da_a, da_b}, 256'd0);
    chk("rst_last", {dl_a, dl_b}, 256'd0);
    chk("rst_sync_out", {so_a, so_b}, 256'd0);
    chk("rst_ovfl", {ov_a, ov_b}, 256'd0);
    rst = 1'b0;

    // valid_in before any sync is ignored
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 16'd5, rnd_word());
    idle(L + 2);
    chk("nosync_dout_a", dout_a, 256'd0);
    chk("nosync_dout_b", dout_b, 256'd0);

    // acc_len=3, 24 back-to-back words, field k = k+1
    pat = '0;
    for (int k = 0; k < NF; k++) pat[k*16 +: 16] = 16'(k + 1);
    step(1'b1, 1'b1, 16'd3, pat);
    for (int i = 1; i < 24; i++) step(1'b1, 1'b0, 16'd3, pat);
    idle(L + 2);

    // same integration with random 0-3 cycle gaps
    step(1'b1, 1'b1, 16'd3, pat);
    for (int i = 1; i < 24; i++) begin
      idle($urandom_range(0, 3));
      step(1'b1, 1'b0, 16'd3, pat);
    end
    idle(L + 2);

    // acc_len 0 and 1: words pass through sign-extended
    step(1'b0, 1'b1, 16'd0, 128'd0);
    for (int i = 0; i < 8; i++) begin
      w = rnd_word(); w[15:0] = 16'hFFFB;
      step(1'b1, 1'b0, 16'd0, w);
    end
    w = rnd_word();
    step(1'b1, 1'b1, 16'd1, w);
    for (int i = 1; i < 8; i++) step(1'b1, 1'b0, 16'd1, rnd_word());
    idle(L + 2);

    // saturation of the 17-bit instance, acc_len=4, all fields +32767
    for (int k = 0; k < NF; k++) pat[k*16 +: 16] = 16'h7FFF;
    step(1'b0, 1'b1, 16'd4, 128'd0);
    for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 16'd4, pat);
    idle(L + 2);
    chk("ovfl_b_set", ov_b, m_ov17);
    chk("ovfl_a_set", ov_a, m_ov32);
    step(1'b0, 1'b1, 16'd1, 128'd0);
    idle(2);
    chk("ovfl_b_clear", ov_b, m_ov17);

    // resync at vector 1 addr 3; old partial integration never dumps
    step(1'b1, 1'b1, 16'd3, rnd_word());
    for (int i = 1; i < 11; i++) step(1'b1, 1'b0, 16'd3, rnd_word());
    step(1'b1, 1'b1, 16'd3, rnd_word());
    for (int i = 1; i < 24; i++) step(1'b1, 1'b0, 16'd3, rnd_word());
    idle(L + 3);

    chk("scoreboard_empty", 256'(sbq.size()), 256'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
